// File: rtl/rom_load_arbiter.sv
// rom_load_arbiter
//   Shares the single ROM-loader port between two load sources
//   (req 0 = boot-flash streamer, req 1 = debug host). Round-robin grants a
//   whole session at a time, pulses rom_loader_reset at session start,
//   counts committed words and holds the CPU in reset until a session
//   drains cleanly.
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   req0/1, load0/1, data0/1   per-source session request, word valid, word
//   grant0/1                   current session owner (one-hot or zero)
//   load_received0/1, ack0/1   loader pulses routed to the owner only
//   rom_loader_reset           1-cycle pulse during START
//   rom_loader_load/data       owner's load/data forwarded while in LOAD
//   rom_loader_ack             loader word-committed pulse
//   rom_loader_load_received   loader word-captured pulse
//   cpu_reset                  hold CPU in reset
//   busy                       session in progress
//   word_count                 acks seen in current/last session (saturating)
//   timeout_err                sticky: last session ended by drain timeout
module rom_load_arbiter #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned COUNT_WIDTH    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req0,
    input  logic                   req1,
    input  logic                   load0,
    input  logic                   load1,
    input  logic [DATA_WIDTH-1:0]  data0,
    input  logic [DATA_WIDTH-1:0]  data1,
    output logic                   grant0,
    output logic                   grant1,
    output logic                   load_received0,
    output logic                   load_received1,
    output logic                   ack0,
    output logic                   ack1,
    output logic                   rom_loader_reset,
    output logic                   rom_loader_load,
    output logic [DATA_WIDTH-1:0]  rom_loader_data,
    input  logic                   rom_loader_ack,
    input  logic                   rom_loader_load_received,
    output logic                   cpu_reset,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] word_count,
    output logic                   timeout_err
);

    localparam int unsigned TIMER_WIDTH = $clog2(TIMEOUT_CYCLES);
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   owner;
    logic                   last_owner;
    logic                   outstanding;
    logic [TIMER_WIDTH-1:0] timer;

    logic active;
    logic owner_req;
    logic owner_load;
    logic lr_pulse;
    logic ack_pulse;
    logic drain_needed;
    logic timed_out;
    logic winner;

    // Loader pulses are only meaningful while a session is moving words.
    assign active     = (state == S_LOAD) || (state == S_DRAIN);
    assign owner_req  = owner ? req1  : req0;
    assign owner_load = owner ? load1 : load0;
    assign lr_pulse   = rom_loader_load_received & active;
    assign ack_pulse  = rom_loader_ack & active;

    // A word captured this cycle, or one still uncommitted, must be drained.
    assign drain_needed = lr_pulse | (outstanding & ~ack_pulse);
    assign timed_out    = (state == S_DRAIN) && !ack_pulse && (timer == TIMER_LAST);

    // Single request wins outright; on a tie the source not served last wins.
    assign winner = (req0 & req1) ? ~last_owner : req1;

    assign load_received0 = rom_loader_load_received & grant0 & active;
    assign load_received1 = rom_loader_load_received & grant1 & active;
    assign ack0           = rom_loader_ack & grant0 & active;
    assign ack1           = rom_loader_ack & grant1 & active;

    // Forwarding stops the cycle the owner drops its request.
    assign rom_loader_load = (state == S_LOAD) & owner_req & owner_load;
    assign rom_loader_data = (state == S_LOAD) ? (owner ? data1 : data0) : '0;

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (req0 | req1) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                state_next = S_LOAD;
            end
            S_LOAD: begin
                if (!owner_req) begin
                    state_next = drain_needed ? S_DRAIN : S_DONE;
                end
            end
            S_DRAIN: begin
                if (ack_pulse || timed_out) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner            <= 1'b0;
            last_owner       <= 1'b1;
            grant0           <= 1'b0;
            grant1           <= 1'b0;
            rom_loader_reset <= 1'b0;
            cpu_reset        <= 1'b1;
            word_count       <= '0;
            timeout_err      <= 1'b0;
            outstanding      <= 1'b0;
            timer            <= '0;
        end else begin
            rom_loader_reset <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req0 | req1) begin
                        owner            <= winner;
                        grant0           <= ~winner;
                        grant1           <= winner;
                        rom_loader_reset <= 1'b1;
                    end
                end
                S_START: begin
                    cpu_reset   <= 1'b1;
                    word_count  <= '0;
                    timeout_err <= 1'b0;
                    outstanding <= 1'b0;
                end
                S_LOAD, S_DRAIN: begin
                    outstanding <= lr_pulse | (outstanding & ~ack_pulse);
                    if (ack_pulse && (word_count != '1)) begin
                        word_count <= word_count + COUNT_WIDTH'(1);
                    end
                    if (state == S_LOAD) begin
                        timer <= '0;
                    end else begin
                        timer <= timer + TIMER_WIDTH'(1);
                    end
                    if (timed_out) begin
                        timeout_err <= 1'b1;
                    end
                end
                S_DONE: begin
                    grant0     <= 1'b0;
                    grant1     <= 1'b0;
                    last_owner <= owner;
                    cpu_reset  <= timeout_err;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_load_arbiter.sv
// tb_rom_load_arbiter
//   Directed bench for rom_load_arbiter with TIMEOUT_CYCLES=8. Inputs are
//   driven 1 time unit after the rising edge; outputs are checked between
//   edges.
module tb_rom_load_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, req1, load0, load1;
    logic [15:0] data0, data1;
    logic        grant0, grant1, load_received0, load_received1, ack0, ack1;
    logic        rom_loader_reset, rom_loader_load;
    logic [15:0] rom_loader_data;
    logic        rom_loader_ack, rom_loader_load_received;
    logic        cpu_reset, busy, timeout_err;
    logic [15:0] word_count;

    int unsigned total;
    int unsigned passed;

    rom_load_arbiter #(
        .DATA_WIDTH    (16),
        .COUNT_WIDTH   (16),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .req0                    (req0),
        .req1                    (req1),
        .load0                   (load0),
        .load1                   (load1),
        .data0                   (data0),
        .data1                   (data1),
        .grant0                  (grant0),
        .grant1                  (grant1),
        .load_received0          (load_received0),
        .load_received1          (load_received1),
        .ack0                    (ack0),
        .ack1                    (ack1),
        .rom_loader_reset        (rom_loader_reset),
        .rom_loader_load         (rom_loader_load),
        .rom_loader_data         (rom_loader_data),
        .rom_loader_ack          (rom_loader_ack),
        .rom_loader_load_received(rom_loader_load_received),
        .cpu_reset               (cpu_reset),
        .busy                    (busy),
        .word_count              (word_count),
        .timeout_err             (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One word from source 0: load, then captured pulse, then commit pulse.
    task automatic do_word(input logic [15:0] v);
        load0 = 1'b1;
        data0 = v;
        #1;
        chk("word_fwd_load", 32'(rom_loader_load), 32'd1);
        chk("word_fwd_data", 32'(rom_loader_data), 32'(v));
        tick();
        load0 = 1'b0;
        rom_loader_load_received = 1'b1;
        #1;
        chk("word_lr0", 32'(load_received0), 32'd1);
        tick();
        rom_loader_load_received = 1'b0;
        rom_loader_ack = 1'b1;
        #1;
        chk("word_ack0", 32'(ack0), 32'd1);
        tick();
        rom_loader_ack = 1'b0;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; load0 = 1'b0; load1 = 1'b0;
        data0 = '0; data1 = '0;
        rom_loader_ack = 1'b0; rom_loader_load_received = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset values
        chk("rst_grant0", 32'(grant0), 32'd0);
        chk("rst_grant1", 32'(grant1), 32'd0);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        chk("rst_rl_reset", 32'(rom_loader_reset), 32'd0);

        // Ack in IDLE is dropped
        rom_loader_ack = 1'b1;
        #1;
        chk("idle_ack0", 32'(ack0), 32'd0);
        tick();
        rom_loader_ack = 1'b0;
        chk("idle_ack_uncounted", 32'(word_count), 32'd0);

        // 1: single source, four words
        req0 = 1'b1;
        tick();
        chk("t1_start_grant0", 32'(grant0), 32'd1);
        chk("t1_start_rl_reset", 32'(rom_loader_reset), 32'd1);
        chk("t1_start_busy", 32'(busy), 32'd1);
        chk("t1_start_cpu_reset", 32'(cpu_reset), 32'd1);
        tick();
        chk("t1_load_rl_reset", 32'(rom_loader_reset), 32'd0);
        do_word(16'h1111);
        do_word(16'h2222);
        do_word(16'h3333);
        do_word(16'h4444);
        chk("t1_word_count", 32'(word_count), 32'd4);
        req0 = 1'b0;
        tick();
        chk("t1_done_grant0", 32'(grant0), 32'd1);
        chk("t1_done_cpu_reset", 32'(cpu_reset), 32'd1);
        tick();
        chk("t1_idle_grant0", 32'(grant0), 32'd0);
        chk("t1_idle_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("t1_idle_busy", 32'(busy), 32'd0);
        chk("t1_idle_word_count", 32'(word_count), 32'd4);

        // 2: round-robin from reset
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        req0 = 1'b1;
        req1 = 1'b1;
        tick();
        chk("t2_tie_grant0", 32'(grant0), 32'd1);
        chk("t2_tie_grant1", 32'(grant1), 32'd0);
        tick();
        req0 = 1'b0;
        tick();
        tick();
        chk("t2_idle_grant1", 32'(grant1), 32'd0);
        tick();
        chk("t2_second_grant1", 32'(grant1), 32'd1);
        chk("t2_second_grant0", 32'(grant0), 32'd0);
        tick();
        req0 = 1'b1;
        tick();
        chk("t2_ignore_grant0", 32'(grant0), 32'd0);
        chk("t2_hold_grant1", 32'(grant1), 32'd1);
        req1 = 1'b0;
        tick();
        req1 = 1'b1;
        tick();
        tick();
        chk("t2_third_grant0", 32'(grant0), 32'd1);
        chk("t2_third_grant1", 32'(grant1), 32'd0);
        tick();
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        tick();

        // 3: drain with late ack
        req0 = 1'b1;
        tick();
        tick();
        load0 = 1'b1;
        data0 = 16'h3030;
        tick();
        load0 = 1'b0;
        rom_loader_load_received = 1'b1;
        tick();
        rom_loader_load_received = 1'b0;
        req0 = 1'b0;
        load0 = 1'b1;
        #1;
        chk("t3_drop_fwd_load", 32'(rom_loader_load), 32'd0);
        tick();
        load0 = 1'b0;
        chk("t3_drain_busy", 32'(busy), 32'd1);
        tick();
        tick();
        tick();
        rom_loader_ack = 1'b1;
        #1;
        chk("t3_drain_ack0", 32'(ack0), 32'd1);
        tick();
        rom_loader_ack = 1'b0;
        chk("t3_word_count", 32'(word_count), 32'd1);
        chk("t3_timeout_err", 32'(timeout_err), 32'd0);
        tick();
        chk("t3_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("t3_idle_busy", 32'(busy), 32'd0);

        // 4: drain timeout
        req0 = 1'b1;
        tick();
        tick();
        rom_loader_load_received = 1'b1;
        tick();
        rom_loader_load_received = 1'b0;
        req0 = 1'b0;
        tick();
        repeat (7) tick();
        chk("t4_pre_busy", 32'(busy), 32'd1);
        chk("t4_pre_timeout_err", 32'(timeout_err), 32'd0);
        tick();
        chk("t4_done_timeout_err", 32'(timeout_err), 32'd1);
        chk("t4_done_cpu_reset", 32'(cpu_reset), 32'd1);
        tick();
        chk("t4_idle_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("t4_idle_busy", 32'(busy), 32'd0);
        chk("t4_idle_timeout_err", 32'(timeout_err), 32'd1);
        req1 = 1'b1;
        tick();
        chk("t4_start_grant1", 32'(grant1), 32'd1);
        tick();
        chk("t4_load_timeout_err", 32'(timeout_err), 32'd0);
        chk("t4_load_word_count", 32'(word_count), 32'd0);
        req1 = 1'b0;
        tick();
        tick();
        chk("t4_clean_cpu_reset", 32'(cpu_reset), 32'd0);

        // 5: non-owner isolation
        req0 = 1'b1;
        tick();
        tick();
        load0 = 1'b1;
        data0 = 16'hA5A5;
        load1 = 1'b1;
        data1 = 16'h1234;
        #1;
        chk("t5_fwd_data", 32'(rom_loader_data), 32'h0000A5A5);
        chk("t5_fwd_load", 32'(rom_loader_load), 32'd1);
        load0 = 1'b0;
        data1 = 16'hFFFF;
        #1;
        chk("t5_fwd_load_nonowner", 32'(rom_loader_load), 32'd0);
        chk("t5_fwd_data_hold", 32'(rom_loader_data), 32'h0000A5A5);
        rom_loader_load_received = 1'b1;
        #1;
        chk("t5_lr0", 32'(load_received0), 32'd1);
        chk("t5_lr1", 32'(load_received1), 32'd0);
        tick();
        rom_loader_load_received = 1'b0;
        rom_loader_ack = 1'b1;
        #1;
        chk("t5_ack0", 32'(ack0), 32'd1);
        chk("t5_ack1", 32'(ack1), 32'd0);
        tick();
        rom_loader_ack = 1'b0;
        load1 = 1'b0;
        chk("t5_word_count", 32'(word_count), 32'd1);

        // 6: reset mid-LOAD
        do_word(16'h7777);
        chk("t6_pre_word_count", 32'(word_count), 32'd2);
        load0 = 1'b1;
        reset = 1'b1;
        tick();
        chk("t6_grant0", 32'(grant0), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("t6_word_count", 32'(word_count), 32'd0);
        chk("t6_fwd_load", 32'(rom_loader_load), 32'd0);
        rom_loader_load_received = 1'b1;
        #1;
        chk("t6_lr0", 32'(load_received0), 32'd0);
        rom_loader_load_received = 1'b0;
        load0 = 1'b0;
        reset = 1'b0;
        tick();
        chk("t6_restart_grant0", 32'(grant0), 32'd1);
        tick();
        do_word(16'h5555);
        chk("t6_fresh_word_count", 32'(word_count), 32'd1);
        req0 = 1'b0;
        tick();
        tick();
        chk("t6_cpu_reset_released", 32'(cpu_reset), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
